// File: rtl/vx_writeback_arb_pkg.sv
// -----------------------------------------------------------------------------
// vx_writeback_arb_pkg
// Shared definitions for the register-file writeback arbiter:
//   - writeback beat width derived from the core configuration fields
//   - control-bit offsets inside a packed beat (eop, sop, tensor)
//   - arbiter FSM state encoding
//   - index-width helper that stays legal for a single requester
// -----------------------------------------------------------------------------
package vx_writeback_arb_pkg;

    // Core configuration fields that make up one writeback beat.
    localparam int UUID_WIDTH  = 44;
    localparam int ISSUE_WIS_W = 4;
    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int NR_BITS     = 5;

    // uuid, wis, tmask, PC, rd, per-thread data, tensor/sop/eop
    localparam int WB_DATA_W = UUID_WIDTH + ISSUE_WIS_W + NUM_THREADS + XLEN
                             + NR_BITS + NUM_THREADS * XLEN + 3;

    localparam int WB_EOP_BIT    = 0;
    localparam int WB_SOP_BIT    = 1;
    localparam int WB_TENSOR_BIT = 2;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // A zero-width index bus is illegal, so one requester still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_writeback_arb_rr_select.sv
// -----------------------------------------------------------------------------
// vx_writeback_arb_rr_select
// Combinational round-robin picker: returns the first asserted request found
// scanning ptr_i, ptr_i+1, ... wrapping modulo NUM_REQS.
// Ports:
//   valid_i       request vector
//   ptr_i         index where the scan starts (highest priority)
//   grant_oh_o    one-hot grant (zero when no request)
//   grant_idx_o   binary index of the grant (0 when no request)
//   grant_vld_o   at least one request was found
// -----------------------------------------------------------------------------
module vx_writeback_arb_rr_select
    import vx_writeback_arb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = idx_w(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] valid_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [NUM_REQS-1:0] grant_oh_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic                grant_vld_o
);

    int   cand;
    logic found;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int off = 0; off < NUM_REQS; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            if (!found && valid_i[cand]) begin
                found            = 1'b1;
                grant_idx_o      = IDX_W'(cand);
                grant_oh_o[cand] = 1'b1;
            end
        end
        grant_vld_o = found;
    end

endmodule

// File: rtl/vx_writeback_arb.sv
// -----------------------------------------------------------------------------
// vx_writeback_arb
// Shares one register-file writeback port among NUM_REQS functional units.
// Round-robin between packets; once a multi-beat packet starts (sop without
// eop) the arbiter locks onto that requester until its eop beat.
// Ports:
//   clk_i, reset_ni    clock, asynchronous active-low reset
//   in_valid_i         per-requester beat valid
//   in_data_i          per-requester packed beats (bit0 eop, bit1 sop, bit2 tensor)
//   in_ready_o         one-hot accept (zero while in reset or when nothing granted)
//   out_valid_o        registered writeback valid
//   out_data_o         registered writeback beat (holds when idle)
//   out_grant_idx_o    source index of out_data_o
//   locked_o           arbiter is locked onto a packet
//   err_proto_o        one-cycle pulse on a sop/eop sequencing violation
//   err_timeout_o      sticky: a lock lasted LOCK_TIMEOUT cycles
// -----------------------------------------------------------------------------
module vx_writeback_arb
    import vx_writeback_arb_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATA_W       = WB_DATA_W,
    parameter int LOCK_TIMEOUT = 64,
    localparam int IDX_W       = idx_w(NUM_REQS),
    localparam int CNT_W       = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [NUM_REQS-1:0]        in_valid_i,
    input  logic [NUM_REQS*DATA_W-1:0] in_data_i,
    output logic [NUM_REQS-1:0]        in_ready_o,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [IDX_W-1:0]           out_grant_idx_o,
    output logic                       locked_o,
    output logic                       err_proto_o,
    output logic                       err_timeout_o
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               err_proto_q, err_proto_d;
    logic               err_timeout_q, err_timeout_d;

    logic [DATA_W-1:0]   beat [NUM_REQS];
    logic [NUM_REQS-1:0] rr_oh;
    logic [IDX_W-1:0]    rr_idx;
    logic                rr_vld;
    logic [NUM_REQS-1:0] grant_oh;
    logic [IDX_W-1:0]    grant_idx;
    logic                transfer;
    logic [DATA_W-1:0]   sel_beat;
    logic                sel_sop;
    logic                sel_eop;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
        assign beat[gi] = in_data_i[gi*DATA_W +: DATA_W];
    end

    vx_writeback_arb_rr_select #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_rr_select (
        .valid_i     (in_valid_i),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (rr_oh),
        .grant_idx_o (rr_idx),
        .grant_vld_o (rr_vld)
    );

    // While locked only the owner can be accepted; its ready follows its valid.
    // Ready is also masked by reset so nothing is accepted while reset is held.
    always_comb begin
        grant_oh  = '0;
        grant_idx = rr_idx;
        if (state_q == ARB_LOCKED) begin
            grant_idx            = lock_idx_q;
            grant_oh[lock_idx_q] = in_valid_i[lock_idx_q];
        end else if (rr_vld) begin
            grant_oh = rr_oh;
        end
        if (!reset_ni) begin
            grant_oh = '0;
        end
    end

    assign in_ready_o = grant_oh;
    assign transfer   = |grant_oh;
    assign sel_beat   = beat[grant_idx];
    assign sel_sop    = sel_beat[WB_SOP_BIT];
    assign sel_eop    = sel_beat[WB_EOP_BIT];

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_idx_d    = lock_idx_q;
        lock_cnt_d    = lock_cnt_q;
        out_valid_d   = transfer;
        out_data_d    = out_data_q;
        out_idx_d     = out_idx_q;
        err_proto_d   = 1'b0;
        err_timeout_d = err_timeout_q;

        if (state_q == ARB_LOCKED && lock_cnt_q < CNT_W'(LOCK_TIMEOUT)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end

        if (transfer) begin
            out_data_d = sel_beat;
            out_idx_d  = grant_idx;
            if (sel_eop) begin
                rr_ptr_d = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == ARB_IDLE) begin
                // A beat without sop outside a packet is flagged but still
                // forwarded; eop decides whether it opens a lock.
                err_proto_d = !sel_sop;
                if (!sel_eop) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = grant_idx;
                    lock_cnt_d = '0;
                end
            end else begin
                // A nested sop is flagged; the lock stays until eop.
                err_proto_d = sel_sop;
                if (sel_eop) begin
                    state_d = ARB_IDLE;
                end
            end
        end

        // Sticky: the lock itself is never broken by the timeout.
        if (state_q == ARB_LOCKED && lock_cnt_d == CNT_W'(LOCK_TIMEOUT)) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            lock_idx_q    <= '0;
            lock_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_idx_q     <= '0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_idx_q    <= lock_idx_d;
            lock_cnt_q    <= lock_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_idx_q     <= out_idx_d;
            err_proto_q   <= err_proto_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_data_o      = out_data_q;
    assign out_grant_idx_o = out_idx_q;
    assign locked_o        = (state_q == ARB_LOCKED);
    assign err_proto_o     = err_proto_q;
    assign err_timeout_o   = err_timeout_q;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// -----------------------------------------------------------------------------
// tb_vx_writeback_arb
// Directed bench for the writeback arbiter (4 requesters, 16-bit beats,
// lock timeout of 8). Each step drives a valid vector, checks in_ready against
// the requester the step is meant to grant, queues the expected beat, and
// compares the registered output one cycle later.
// -----------------------------------------------------------------------------
module tb_vx_writeback_arb;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int TOUT = 8;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_grant_idx;
    logic          locked;
    logic          err_proto;
    logic          err_timeout;

    logic [DW-1:0]   beat [N];
    logic [DW+1:0]   sb [$];
    int              checks = 0;
    int              errors = 0;
    int              seq    = 0;
    logic [DW-1:0]   exp_last;

    assign in_data = {beat[3], beat[2], beat[1], beat[0]};

    vx_writeback_arb #(
        .NUM_REQS     (N),
        .DATA_W       (DW),
        .LOCK_TIMEOUT (TOUT)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .in_valid_i      (in_valid),
        .in_data_i       (in_data),
        .in_ready_o      (in_ready),
        .out_valid_o     (out_valid),
        .out_data_o      (out_data),
        .out_grant_idx_o (out_grant_idx),
        .locked_o        (locked),
        .err_proto_o     (err_proto),
        .err_timeout_o   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int r, input bit sop, input bit eop);
        seq++;
        beat[r] = {4'(r), 9'(seq), 1'b0, sop, eop};
    endtask

    task automatic all_single();
        for (int r = 0; r < N; r++) set_beat(r, 1'b1, 1'b1);
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic [N-1:0] v, input int exp_idx, input string tag);
        logic [N-1:0]  exp_rdy;
        logic [DW+1:0] ent;
        in_valid = v;
        #1;
        exp_rdy = (exp_idx < 0) ? '0 : (N'(1) << exp_idx);
        chk({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
        if (exp_idx >= 0) sb.push_back({2'(exp_idx), beat[exp_idx]});
        @(posedge clk);
        #1;
        chk({tag, ".ov"}, 32'(out_valid), 32'(exp_idx >= 0));
        if (out_valid) begin
            if (sb.size() > 0) begin
                ent = sb.pop_front();
                chk({tag, ".data"}, 32'(out_data), 32'(ent[DW-1:0]));
                chk({tag, ".idx"}, 32'(out_grant_idx), 32'(ent[DW+1:DW]));
            end else begin
                chk({tag, ".unexpected"}, 32'(out_valid), 32'd0);
            end
        end else if (sb.size() > 0) begin
            sb.delete();
        end
        $display("step %s valid=%b ready=%b out_valid=%0d idx=%0d data=%h locked=%0d ep=%0d et=%0d",
                 tag, v, exp_rdy, out_valid, out_grant_idx, out_data, locked, err_proto, err_timeout);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = '0;
        for (int r = 0; r < N; r++) beat[r] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.out_idx", 32'(out_grant_idx), 32'd0);
        chk("rst.locked", 32'(locked), 32'd0);
        chk("rst.err_proto", 32'(err_proto), 32'd0);
        chk("rst.err_timeout", 32'(err_timeout), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fairness: all valid, single-beat packets
        for (int k = 0; k < 8; k++) begin
            all_single();
            exp_last = beat[k % N];
            step(4'hF, k % N, $sformatf("fair%0d", k));
            chk($sformatf("fair%0d.locked", k), 32'(locked), 32'd0);
        end
        step(4'h0, -1, "idle");
        chk("idle.hold", 32'(out_data), 32'(exp_last));

        // Packet lock: req1 3-beat packet with req0/req2 competing
        set_beat(0, 1'b1, 1'b1);
        step(4'b0001, 0, "pl.pre");
        set_beat(0, 1'b1, 1'b1);
        set_beat(1, 1'b1, 1'b0);
        set_beat(2, 1'b1, 1'b1);
        step(4'b0111, 1, "pl.b0");
        chk("pl.b0.locked", 32'(locked), 32'd1);
        set_beat(1, 1'b0, 1'b0);
        step(4'b0111, 1, "pl.b1");
        chk("pl.b1.locked", 32'(locked), 32'd1);
        set_beat(1, 1'b0, 1'b1);
        step(4'b0111, 1, "pl.b2");
        chk("pl.b2.locked", 32'(locked), 32'd0);
        step(4'b0101, 2, "pl.next");
        chk("pl.err_proto", 32'(err_proto), 32'd0);

        // Lock stall: req3 locked then silent for 5 cycles
        all_single();
        set_beat(3, 1'b1, 1'b0);
        step(4'hF, 3, "st.sop");
        for (int k = 0; k < 5; k++) begin
            step(4'b0111, -1, $sformatf("st.wait%0d", k));
            chk($sformatf("st.wait%0d.locked", k), 32'(locked), 32'd1);
            chk($sformatf("st.wait%0d.ep", k), 32'(err_proto), 32'd0);
        end
        chk("st.lock_cnt", 32'(dut.lock_cnt_q), 32'd5);
        chk("st.err_timeout", 32'(err_timeout), 32'd0);
        set_beat(3, 1'b0, 1'b1);
        step(4'hF, 3, "st.eop");
        chk("st.eop.locked", 32'(locked), 32'd0);

        // Protocol error in IDLE: sop=0, eop=1
        set_beat(2, 1'b0, 1'b1);
        step(4'b0100, 2, "pi");
        chk("pi.err_proto", 32'(err_proto), 32'd1);
        chk("pi.locked", 32'(locked), 32'd0);
        step(4'b0000, -1, "pi.after");
        chk("pi.after.err_proto", 32'(err_proto), 32'd0);

        // Protocol error in LOCKED: nested sop
        set_beat(1, 1'b1, 1'b0);
        step(4'b0010, 1, "pk.sop");
        chk("pk.sop.err_proto", 32'(err_proto), 32'd0);
        chk("pk.sop.locked", 32'(locked), 32'd1);
        set_beat(1, 1'b1, 1'b0);
        step(4'b0010, 1, "pk.sop2");
        chk("pk.sop2.err_proto", 32'(err_proto), 32'd1);
        chk("pk.sop2.locked", 32'(locked), 32'd1);
        set_beat(1, 1'b0, 1'b1);
        step(4'b0010, 1, "pk.eop");
        chk("pk.eop.err_proto", 32'(err_proto), 32'd0);
        chk("pk.eop.locked", 32'(locked), 32'd0);
        chk("pk.err_timeout", 32'(err_timeout), 32'd0);

        // Timeout: req0 sop then silent
        set_beat(0, 1'b1, 1'b0);
        step(4'b0001, 0, "to.sop");
        for (int k = 1; k < TOUT; k++) begin
            step(4'b0000, -1, $sformatf("to.wait%0d", k));
            chk($sformatf("to.wait%0d.et", k), 32'(err_timeout), 32'd0);
        end
        step(4'b0000, -1, "to.expire");
        chk("to.expire.et", 32'(err_timeout), 32'd1);
        chk("to.expire.locked", 32'(locked), 32'd1);
        set_beat(0, 1'b0, 1'b1);
        step(4'b0001, 0, "to.eop");
        chk("to.eop.locked", 32'(locked), 32'd0);
        chk("to.eop.et", 32'(err_timeout), 32'd1);
        step(4'b0000, -1, "to.after");
        chk("to.after.et", 32'(err_timeout), 32'd1);

        // Async reset mid-packet
        set_beat(2, 1'b1, 1'b0);
        step(4'b0100, 2, "ar.sop");
        chk("ar.sop.locked", 32'(locked), 32'd1);
        all_single();
        in_valid = 4'hF;
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar.out_valid", 32'(out_valid), 32'd0);
        chk("ar.locked", 32'(locked), 32'd0);
        chk("ar.in_ready", 32'(in_ready), 32'd0);
        chk("ar.err_timeout", 32'(err_timeout), 32'd0);
        chk("ar.out_data", 32'(out_data), 32'd0);
        in_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        set_beat(2, 1'b0, 1'b1);
        step(4'hF, 0, "ar.first");
        step(4'hF, 1, "ar.second");
        step(4'hF, 2, "ar.orphan");
        chk("ar.orphan.err_proto", 32'(err_proto), 32'd1);
        chk("ar.orphan.locked", 32'(locked), 32'd0);
        step(4'h0, -1, "ar.idle");

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_writeback_arb.md
Name: VX_writeback_arb

Overview:
- Shares one register-file writeback port among NUM_REQS functional-unit requesters (ALU, LSU, FPU, SFU, ...).
- Round-robin arbitration with packet locking: a multi-beat writeback (sop..eop) is never interleaved with another requester's beats.
- One registered output stage drives the writeback master valid/data bundle consumed by the register file and scoreboard.
- The output bundle has no back-pressure, so a granted beat is always consumed.

Parameters:
- NUM_REQS, 4, number of requesters (2..16).
- DATA_W, `UUID_WIDTH+ISSUE_WIS_W+`NUM_THREADS+`XLEN+`NR_BITS+`NUM_THREADS*`XLEN+3, width of one packed writeback beat.
- LOCK_TIMEOUT, 64, cycles a lock may be held without eop before the timeout flag is raised.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_REQS  per-requester beat valid.
- in_data  in  NUM_REQS*DATA_W  per-requester packed beat. Bit 0 = eop, bit 1 = sop, bit 2 = tensor; remaining fields packed above, in writeback bundle order.
- in_ready  out  NUM_REQS  per-requester accept (one-hot or zero).
- out_valid  out  1  writeback valid.
- out_data  out  DATA_W  writeback beat.
- out_grant_idx  out  clog2(NUM_REQS)  source index of the current out_data.
- locked  out  1  arbiter is in LOCKED state.
- err_proto  out  1  one-cycle pulse on a protocol violation.
- err_timeout  out  1  sticky lock-timeout flag.

Behaviour:
- Reset (async assert, sync deassert) forces these values:
  - out_valid=0, out_data=0, out_grant_idx=0.
  - rr_ptr=0, state=IDLE, lock_idx=0, lock_cnt=0.
  - err_proto=0, err_timeout=0.
- Reset mid-packet drops the lock. The abandoned packet's remaining beats arrive with sop=0 and are handled as protocol errors.
- Grant is combinational from registered state.
- In IDLE, the granted requester is the first valid index found scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQS.
- In LOCKED, only lock_idx may be granted; its in_ready equals its in_valid, and all other in_ready are 0.
- in_ready = grant (one-hot). A beat transfers when in_valid[i] & in_ready[i].
- Latency is 1 cycle: out_valid <= |transfer, out_data <= the selected beat, out_grant_idx <= the granted index. With no transfer, out_valid=0 and out_data holds its value.
- FSM IDLE -> LOCKED: transferred beat has sop=1, eop=0. lock_idx <= granted index, lock_cnt <= 0.
- FSM LOCKED -> IDLE: lock_idx transfers a beat with eop=1.
- Single-beat packets (sop=1, eop=1) never lock.
- rr_ptr <= (granted index + 1) mod NUM_REQS whenever a transferred beat has eop=1. rr_ptr holds while LOCKED.
- err_proto pulses for one cycle when either of these occurs:
  - In IDLE, a transferred beat has sop=0. The beat is still forwarded and treated as packet end if eop=1, otherwise as a lock start.
  - In LOCKED, the lock owner transfers a beat with sop=1. The beat is forwarded and the lock is retained.
- lock_cnt increments every LOCKED cycle and saturates at LOCK_TIMEOUT.
- err_timeout sets when lock_cnt reaches LOCK_TIMEOUT and clears only on reset. The lock is never broken by the timeout.
- Simultaneous events:
  - When the eop transfer and a new request from another index occur in the same cycle, the new requester is arbitrated the next cycle using the updated rr_ptr.
  - When IDLE and all in_valid=0, there is no grant and rr_ptr is unchanged.
- NUM_REQS=1 degenerates to a pass-through register with locking and error checks intact.

Decomposition:
- Shared in VX_gpu_pkg:
  - writeback beat width constant (WB_DATA_W).
  - field offsets (WB_EOP_BIT=0, WB_SOP_BIT=1, WB_TENSOR_BIT=2).
  - arbiter state enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module VX_rr_select (NUM_REQS): inputs valid vector and start pointer; outputs one-hot grant and index; purely combinational.
- The top level holds the FSM, counters, error logic and output register.

Test Plan:
- Fairness: NUM_REQS=4, all valid with single-beat packets for 8 cycles -> out_grant_idx sequence 0,1,2,3,0,1,2,3 starting one cycle after the first valid; exactly one in_ready high per cycle.
- Packet lock: req1 sends a 3-beat packet (sop/-/eop) while req0 and req2 stay valid -> three consecutive outputs from idx 1, locked=1 for 2 cycles, then grant goes to idx 2.
- Lock stall: req3 locked and deasserts valid for 5 cycles mid-packet while others are valid -> no grants, out_valid=0 for 5 cycles, lock_cnt=5, no error flags.
- Timeout: LOCK_TIMEOUT=8, req0 sends sop only and then stays silent -> err_timeout=1 after 8 LOCKED cycles; it remains 1 after req0 sends eop and only clears on reset.
- Protocol errors: in IDLE req2 sends sop=0, eop=1 -> beat forwarded and err_proto pulses once. While req1 is locked it sends sop=1 -> err_proto pulses and locked stays 1.
- Async reset: assert reset low mid-packet between clock edges -> out_valid=0, locked=0 and in_ready=0 immediately. After release, req0 is granted first when all requesters are valid.
